// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file and its rename status.
// Used by the ROB, RS and LSB as well; tags index the reorder buffer.
package register_file_pkg;

  localparam int ROB_SIZE = 32;
  localparam int ENTRY_W  = $clog2(ROB_SIZE);
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [REG_W-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0]    word_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    entry_t   entry;
    word_t    value;
  } commit_t;

  // A commit retires the pending producer only if it is the most recent rename.
  function automatic logic tag_match(logic busy, entry_t tag, entry_t entry);
    return busy && (tag == entry);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Issue/commit/query bundle between the pipeline and the register file.
// master drives issue, commit and query addresses; slave is the register file.
interface register_file_if;
  import register_file_pkg::*;

  logic     rdy_in;
  logic     roll_back;

  logic     issue_valid;
  reg_idx_t issue_rd;
  entry_t   issue_entry;

  logic     commit_valid;
  reg_idx_t commit_rd;
  entry_t   commit_entry;
  word_t    commit_value;

  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  logic     rs1_busy;
  logic     rs2_busy;
  entry_t   rs1_tag;
  entry_t   rs2_tag;
  word_t    rs1_value;
  word_t    rs2_value;

  modport master (
    output rdy_in, roll_back,
    output issue_valid, issue_rd, issue_entry,
    output commit_valid, commit_rd, commit_entry, commit_value,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value
  );

  modport slave (
    input  rdy_in, roll_back,
    input  issue_valid, issue_rd, issue_entry,
    input  commit_valid, commit_rd, commit_entry, commit_value,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational operand query port: x0 handling plus optional same-cycle commit bypass
// (enabled by REGFILE_COMMIT_BYPASS_EN).
module regfile_read_port
  import register_file_pkg::*;
(
  input  reg_idx_t                    addr,
  input  logic   [NUM_REGS-1:0]       busy_vec,
  input  entry_t [NUM_REGS-1:0]       tag_vec,
  input  word_t  [NUM_REGS-1:0]       value_vec,
`ifdef REGFILE_COMMIT_BYPASS_EN
  input  logic                        rdy,
  input  commit_t                     commit,
`endif
  output logic                        busy,
  output entry_t                      tag,
  output word_t                       value
);

  always_comb begin
    busy  = FALSE;
    tag   = '0;
    value = '0;
    if (addr != '0) begin
      busy  = busy_vec[addr];
      tag   = tag_vec[addr];
      value = value_vec[addr];
`ifdef REGFILE_COMMIT_BYPASS_EN
      // The producer this query waits on is retiring right now: forward its result.
      if (rdy && commit.valid && commit.rd == addr &&
          tag_match(busy_vec[addr], tag_vec[addr], commit.entry)) begin
        busy  = FALSE;
        value = commit.value;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Optional same-cycle commit forwarding on the query ports: REGFILE_COMMIT_BYPASS_EN.
module register_file
  import register_file_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  register_file_if.slave  bus
);

  logic   [NUM_REGS-1:0] busy_vec;
  entry_t [NUM_REGS-1:0] tag_vec;
  word_t  [NUM_REGS-1:0] value_vec;

  // x0 has no storage; its slot is hard-wired so read ports can index uniformly.
  assign busy_vec[0]  = FALSE;
  assign tag_vec[0]   = '0;
  assign value_vec[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic   busy_reg;
      entry_t tag_reg;
      word_t  value_reg;
      logic   issue_hit;
      logic   commit_hit;

      assign issue_hit  = bus.rdy_in && !bus.roll_back && bus.issue_valid &&
                          (bus.issue_rd == REG_W'(gi));
      assign commit_hit = bus.rdy_in && bus.commit_valid &&
                          (bus.commit_rd == REG_W'(gi));

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          busy_reg  <= FALSE;
          tag_reg   <= '0;
          value_reg <= '0;
        end else begin
          if (commit_hit)
            value_reg <= bus.commit_value;
          // Priority: flush, then a new rename, then retirement of the current producer.
          if (bus.rdy_in && bus.roll_back) begin
            busy_reg <= FALSE;
          end else if (issue_hit) begin
            busy_reg <= TRUE;
            tag_reg  <= bus.issue_entry;
          end else if (commit_hit && tag_match(busy_reg, tag_reg, bus.commit_entry)) begin
            busy_reg <= FALSE;
          end
        end
      end

      assign busy_vec[gi]  = busy_reg;
      assign tag_vec[gi]   = tag_reg;
      assign value_vec[gi] = value_reg;
    end
  endgenerate

`ifdef REGFILE_COMMIT_BYPASS_EN
  commit_t commit_bus;
  assign commit_bus = '{valid: bus.commit_valid, rd: bus.commit_rd,
                        entry: bus.commit_entry, value: bus.commit_value};
`endif

  regfile_read_port u_rs1 (
    .addr      (bus.rs1_addr),
    .busy_vec  (busy_vec),
    .tag_vec   (tag_vec),
    .value_vec (value_vec),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .rdy       (bus.rdy_in),
    .commit    (commit_bus),
`endif
    .busy      (bus.rs1_busy),
    .tag       (bus.rs1_tag),
    .value     (bus.rs1_value)
  );

  regfile_read_port u_rs2 (
    .addr      (bus.rs2_addr),
    .busy_vec  (busy_vec),
    .tag_vec   (tag_vec),
    .value_vec (value_vec),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .rdy       (bus.rdy_in),
    .commit    (commit_bus),
`endif
    .busy      (bus.rs2_busy),
    .tag       (bus.rs2_tag),
    .value     (bus.rs2_value)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a rule-level model checked every negedge,
// plus hand-computed literal expectations after each scenario.
module tb_register_file;
  import register_file_pkg::*;

  logic clk_in;
  logic rst_in;
  int   checks = 0;
  int   errors = 0;

  register_file_if rf_if ();

  register_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (rf_if.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Model: architectural state updated by the commit/issue/flush rules.
  logic [31:0] m_value [32];
  logic        m_busy  [32];
  logic [4:0]  m_tag   [32];

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_value[i] <= '0;
        m_busy[i]  <= 1'b0;
        m_tag[i]   <= '0;
      end
    end else if (rf_if.rdy_in) begin
      if (rf_if.commit_valid && rf_if.commit_rd != 0) begin
        m_value[rf_if.commit_rd] <= rf_if.commit_value;
        if (m_busy[rf_if.commit_rd] && m_tag[rf_if.commit_rd] == rf_if.commit_entry)
          m_busy[rf_if.commit_rd] <= 1'b0;
      end
      if (rf_if.roll_back) begin
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end else if (rf_if.issue_valid && rf_if.issue_rd != 0) begin
        m_busy[rf_if.issue_rd] <= 1'b1;
        m_tag[rf_if.issue_rd]  <= rf_if.issue_entry;
      end
    end
  end

  function automatic logic bypass_hit(logic [4:0] a);
`ifdef REGFILE_COMMIT_BYPASS_EN
    return rf_if.rdy_in && rf_if.commit_valid && a != 0 && a == rf_if.commit_rd &&
           m_busy[a] && m_tag[a] == rf_if.commit_entry;
`else
    return (a == 5'd31) && 1'b0 && rf_if.rdy_in;
`endif
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    if (a == 0 || bypass_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_value(logic [4:0] a);
    if (a == 0) return '0;
    if (bypass_hit(a)) return rf_if.commit_value;
    return m_value[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_port(input string name, input logic [4:0] a, input logic busy,
                            input logic [4:0] tag, input logic [31:0] value);
    logic eb;
    eb = exp_busy(a);
    chk({name, "_busy"}, 32'(busy), 32'(eb));
    if (eb) chk({name, "_tag"}, 32'(tag), 32'(m_tag[a]));
    else    chk({name, "_value"}, value, exp_value(a));
  endtask

  // Compare process: query outputs against the model every cycle out of reset.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      check_port("model_rs1", rf_if.rs1_addr, rf_if.rs1_busy, rf_if.rs1_tag, rf_if.rs1_value);
      check_port("model_rs2", rf_if.rs2_addr, rf_if.rs2_busy, rf_if.rs2_tag, rf_if.rs2_value);
    end
  end

  task automatic clear();
    rf_if.rdy_in       = 1'b1;
    rf_if.roll_back    = 1'b0;
    rf_if.issue_valid  = 1'b0;
    rf_if.issue_rd     = '0;
    rf_if.issue_entry  = '0;
    rf_if.commit_valid = 1'b0;
    rf_if.commit_rd    = '0;
    rf_if.commit_entry = '0;
    rf_if.commit_value = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic q(input logic [4:0] a1, input logic [4:0] a2);
    rf_if.rs1_addr = a1;
    rf_if.rs2_addr = a2;
    #1;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [4:0] e);
    rf_if.issue_valid = 1'b1;
    rf_if.issue_rd    = rd;
    rf_if.issue_entry = e;
  endtask

  task automatic set_commit(input logic [4:0] rd, input logic [4:0] e, input logic [31:0] v);
    rf_if.commit_valid = 1'b1;
    rf_if.commit_rd    = rd;
    rf_if.commit_entry = e;
    rf_if.commit_value = v;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] e);
    set_issue(rd, e);
    tick();
    clear();
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] e, input logic [31:0] v);
    set_commit(rd, e, v);
    tick();
    clear();
  endtask

  initial begin
    rst_in = 1'b1;
    clear();
    rf_if.rs1_addr = 5'd5;
    rf_if.rs2_addr = 5'd0;
    #12;
    chk("rst_rs1_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("rst_rs1_value", rf_if.rs1_value, 32'd0);
    chk("rst_rs1_tag", 32'(rf_if.rs1_tag), 32'd0);
    chk("rst_rs2_busy", 32'(rf_if.rs2_busy), 32'd0);
    chk("rst_rs2_value", rf_if.rs2_value, 32'd0);
    chk("rst_rs2_tag", 32'(rf_if.rs2_tag), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Rename then retire.
    issue(5'd5, 5'd3);
    q(5'd5, 5'd0);
    chk("issue5_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("issue5_tag", 32'(rf_if.rs1_tag), 32'd3);
    commit(5'd5, 5'd3, 32'hDEADBEEF);
    q(5'd5, 5'd0);
    chk("commit5_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("commit5_value", rf_if.rs1_value, 32'hDEADBEEF);

    // Older producer commits while a younger one is pending.
    issue(5'd7, 5'd2);
    issue(5'd7, 5'd9);
    commit(5'd7, 5'd2, 32'h11);
    q(5'd7, 5'd7);
    chk("stale7_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("stale7_tag", 32'(rf_if.rs1_tag), 32'd9);
    chk("stale7_value_stored", rf_if.rs2_value, 32'h11);
    commit(5'd7, 5'd9, 32'h22);
    q(5'd7, 5'd0);
    chk("young7_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("young7_value", rf_if.rs1_value, 32'h22);

    // Same-cycle issue and commit: issue wins the status, value still written.
    set_commit(5'd4, 5'd1, 32'h55);
    set_issue(5'd4, 5'd6);
    tick();
    clear();
    q(5'd4, 5'd4);
    chk("same4_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("same4_tag", 32'(rf_if.rs1_tag), 32'd6);
    chk("same4_value", rf_if.rs2_value, 32'h55);

    // Flush with a concurrent commit and an ignored issue.
    issue(5'd3, 5'd10);
    issue(5'd8, 5'd11);
    issue(5'd12, 5'd12);
    rf_if.roll_back = 1'b1;
    set_commit(5'd8, 5'd11, 32'h77);
    set_issue(5'd13, 5'd13);
    tick();
    clear();
    q(5'd3, 5'd8);
    chk("rb3_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("rb8_busy", 32'(rf_if.rs2_busy), 32'd0);
    chk("rb8_value", rf_if.rs2_value, 32'h77);
    q(5'd12, 5'd13);
    chk("rb12_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("rb13_busy", 32'(rf_if.rs2_busy), 32'd0);
    q(5'd4, 5'd7);
    chk("rb4_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("rb4_value", rf_if.rs1_value, 32'h55);

    // x0 ignores issue and commit.
    set_issue(5'd0, 5'd5);
    set_commit(5'd0, 5'd5, 32'h99);
    tick();
    clear();
    q(5'd0, 5'd0);
    chk("x0_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("x0_value", rf_if.rs1_value, 32'd0);
    chk("x0_tag", 32'(rf_if.rs2_tag), 32'd0);

    // rdy_in low holds everything, including a flush.
    issue(5'd10, 5'd4);
    rf_if.rdy_in = 1'b0;
    rf_if.roll_back = 1'b1;
    set_issue(5'd20, 5'd1);
    set_commit(5'd5, 5'd3, 32'h1234);
    tick();
    clear();
    q(5'd10, 5'd5);
    chk("hold10_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("hold10_tag", 32'(rf_if.rs1_tag), 32'd4);
    chk("hold5_value", rf_if.rs2_value, 32'hDEADBEEF);
    q(5'd20, 5'd5);
    chk("hold20_busy", 32'(rf_if.rs1_busy), 32'd0);

    // Commit of the pending producer while paused, then while running.
    rf_if.rdy_in = 1'b0;
    set_commit(5'd10, 5'd4, 32'hAB);
    q(5'd10, 5'd0);
    chk("byp_paused_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("byp_paused_tag", 32'(rf_if.rs1_tag), 32'd4);
    tick();
    rf_if.rdy_in = 1'b1;
    q(5'd10, 5'd0);
`ifdef REGFILE_COMMIT_BYPASS_EN
    chk("byp_live_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("byp_live_value", rf_if.rs1_value, 32'hAB);
`else
    chk("byp_live_busy", 32'(rf_if.rs1_busy), 32'd1);
    chk("byp_live_tag", 32'(rf_if.rs1_tag), 32'd4);
`endif
    tick();
    clear();
    q(5'd10, 5'd0);
    chk("after10_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("after10_value", rf_if.rs1_value, 32'hAB);

    // Commit to an idle register, and a mismatched commit to a busy one.
    commit(5'd7, 5'd5, 32'h33);
    issue(5'd10, 5'd6);
    commit(5'd10, 5'd7, 32'h44);
    q(5'd7, 5'd10);
    chk("idle7_value", rf_if.rs1_value, 32'h33);
    chk("mis10_busy", 32'(rf_if.rs2_busy), 32'd1);
    chk("mis10_tag", 32'(rf_if.rs2_tag), 32'd6);
    commit(5'd10, 5'd6, 32'h45);
    q(5'd10, 5'd0);
    chk("match10_value", rf_if.rs1_value, 32'h45);

    // Asynchronous reset with an issue and commit pending across the edge.
    set_issue(5'd15, 5'd8);
    set_commit(5'd5, 5'd2, 32'h5A5A);
    #2;
    rst_in = 1'b1;
    #1;
    q(5'd5, 5'd10);
    chk("arst_rs1_value", rf_if.rs1_value, 32'd0);
    chk("arst_rs2_value", rf_if.rs2_value, 32'd0);
    tick();
    clear();
    rst_in = 1'b0;
    q(5'd15, 5'd5);
    chk("arst15_busy", 32'(rf_if.rs1_busy), 32'd0);
    chk("arst5_value", rf_if.rs2_value, 32'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
